alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//   Consumes the ALU decoder outputs: 4-bit ALU op code plus two one-hot register selects (regsel[7:4] = first operand/dest, regsel[3:0] = second operand, bit order DCBA).
//   Holds the 4-entry register file (A..D), reads both operands and latches them with the op code into a valid/ready pipeline register.
//   Feeds the ALU execute stage. Accepts one-hot writeback from that stage.
// PARAMETERS
//   DATA_W    8   register/operand width
//   RST_VAL   0   reset value of every register-file entry
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   in_valid   in   1       decoder output valid
//   in_ready   out  1       stage can accept this cycle
//   in_code    in   4       ALU op code from decoder
//   in_regsel  in   8       {sel1[3:0], sel2[3:0]} one-hot DCBA selects
//   wb_en      in   1       writeback strobe
//   wb_sel     in   4       one-hot writeback target, DCBA
//   wb_data    in   DATA_W  writeback value
//   out_valid  out  1       operands valid to ALU
//   out_ready  in   1       ALU accepts
//   out_code   out  4       latched op code
//   out_opa    out  DATA_W  operand from sel1
//   out_opb    out  DATA_W  operand from sel2
//   out_dst    out  4       latched sel1 (destination one-hot)
//   sel_err    out  1       sticky: a select or wb_sel nibble was not one-hot
//   err_clr    in   1       clears sel_err (set wins if same cycle)
// BEHAVIOUR
//   - Reset (async, rst_n=0): out_valid=0, out_code/out_opa/out_opb/out_dst=0, sel_err=0, all regs=RST_VAL. Reset mid-transfer drops the held entry.
//   - Transfer: in_valid & in_ready. Latency 1 clk: operands are visible on out_* the next cycle with out_valid=1.
//   - in_ready = (!out_valid | out_ready) & !hazard. Back-to-back issue at full rate when out_ready=1.
//   - out_valid stays high and out_* stay stable until out_valid & out_ready.
//   - Read: opa = reg[sel1], opb = reg[sel2]. sel1==sel2 is legal and gives both the same value.
//   - Zero-hot or multi-hot select: that operand = 0, transfer still occurs, sel_err set next cycle.
//   - Writeback: wb_en & one-hot wb_sel writes wb_data at the clock edge. Non-one-hot wb_sel: no write, sel_err set.
//   - Writeback never alters operands already latched in the output register.
//   - Hazard = wb_en & one-hot wb_sel & (wb_sel & (sel1|sel2)) != 0 during a read cycle. Its handling is set by the macro below.
// CONFIGURATION
//   ALU_OPSTAGE_BYPASS_EN defined:
//     hazard is forced to 0; the matching operand takes wb_data in the same cycle.
//   Not defined:
//     hazard deasserts in_ready for that cycle.
//     The decoder holds its inputs; the read retries next cycle and sees the written value.
// STRUCTURE
//   Package alu_op_pkg:
//     DATA_W default
//     one-hot constants REG_A=4'b0001, REG_B=4'b0010, REG_C=4'b0100, REG_D=4'b1000
//     function is_onehot4()
//     op-code width constant (4)
//   Sub-module regfile4:
//     4 x DATA_W flops, async reset
//     one one-hot write port
//     two combinational one-hot read ports, returning 0 on an invalid select
//   Top level holds the pipeline register, handshake, hazard/bypass and sel_err logic.
// TESTING
//   1. Reset, then wb A=0x11, B=0x22 (separate cycles); issue regsel=8'b0001_0010, code=3
//      -> next cycle out_valid=1, opa=0x11, opb=0x22, code=3, dst=0001.
//   2. out_ready=0 for 3 cycles with a held entry
//      -> out_* stable, in_ready=0. Then out_ready=1 -> entry drains, next entry accepted the same cycle.
//   3. Issue regsel=8'b0100_0100 while wb C=0x5A.
//      With BYPASS_EN: opa=opb=0x5A, no stall.
//      Without: in_ready=0 one cycle, then opa=opb=0x5A.
//   4. Issue regsel=8'b0011_0000 -> opa=0, opb=0, sel_err=1; err_clr=1 -> sel_err=0.
//      wb_sel=4'b0110 -> no register changes, sel_err=1.
//   5. rst_n low mid-stream with out_valid=1 -> out_valid=0 immediately, registers=RST_VAL.
//   6. Issue D,A, then wb D=0xFF the cycle after the transfer -> latched opa keeps the old D value.

Source files
------------

// File: rtl/alu_op_pkg.sv
// alu_op_pkg: shared constants for the ALU operand stage.
//   DEF_DATA_W   default register/operand width
//   OP_W         ALU op-code width
//   REG_A..REG_D one-hot register selects, bit order DCBA
//   is_onehot4() true when exactly one bit of a nibble is set
package alu_op_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int OP_W       = 4;

    localparam logic [3:0] REG_A = 4'b0001;
    localparam logic [3:0] REG_B = 4'b0010;
    localparam logic [3:0] REG_C = 4'b0100;
    localparam logic [3:0] REG_D = 4'b1000;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/regfile4.sv
// regfile4: four-entry register file (A..D) addressed by one-hot selects.
//   clk, rst_n            clock, async active-low reset (entries -> RST_VAL)
//   wr_en, wr_sel, wr_data one write port; wr_sel must already be one-hot
//   rd_sel_a / rd_data_a  combinational read port, 0 on a non-one-hot select
//   rd_sel_b / rd_data_b  second combinational read port, same rules
module regfile4
    import alu_op_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_sel_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [3:0]        rd_sel_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [4];

    for (genvar i = 0; i < 4; i++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                regs[i] <= RST_VAL;
            else if (wr_en && wr_sel[i])
                regs[i] <= wr_data;
        end
    end

    // Full-nibble decode so zero-hot and multi-hot selects read as 0.
    always_comb begin
        rd_data_a = '0;
        case (rd_sel_a)
            REG_A:   rd_data_a = regs[0];
            REG_B:   rd_data_a = regs[1];
            REG_C:   rd_data_a = regs[2];
            REG_D:   rd_data_a = regs[3];
            default: rd_data_a = '0;
        endcase
    end

    always_comb begin
        rd_data_b = '0;
        case (rd_sel_b)
            REG_A:   rd_data_b = regs[0];
            REG_B:   rd_data_b = regs[1];
            REG_C:   rd_data_b = regs[2];
            REG_D:   rd_data_b = regs[3];
            default: rd_data_b = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register-file read stage between the ALU decoder and
// the ALU execute stage. Reads two operands by one-hot select, latches them
// with the op code into a single valid/ready output register, and accepts
// one-hot writeback from the execute stage.
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready decoder handshake; in_code, in_regsel = {sel1, sel2}
//   wb_en/wb_sel/wb_data one-hot writeback into the register file
//   out_valid/out_ready ALU handshake; out_code, out_opa, out_opb, out_dst
//   sel_err/err_clr   sticky non-one-hot select/writeback flag and its clear
// Build option: define ALU_OPSTAGE_BYPASS_EN to forward same-cycle writeback
// data into the operands instead of stalling the read for one cycle.
module alu_operand_stage
    import alu_op_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_code,
    input  logic [7:0]        in_regsel,
    input  logic              wb_en,
    input  logic [3:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_code,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb,
    output logic [3:0]        out_dst,
    output logic              sel_err,
    input  logic              err_clr
);

    logic [3:0]        sel1, sel2;
    logic              wb_ok, hazard, xfer, err_set;
    logic [DATA_W-1:0] rd_a, rd_b, opa_nxt, opb_nxt;

    assign sel1  = in_regsel[7:4];
    assign sel2  = in_regsel[3:0];
    assign wb_ok = wb_en && is_onehot4(wb_sel);

    regfile4 #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wb_ok),
        .wr_sel    (wb_sel),
        .wr_data   (wb_data),
        .rd_sel_a  (sel1),
        .rd_data_a (rd_a),
        .rd_sel_b  (sel2),
        .rd_data_b (rd_b)
    );

`ifdef ALU_OPSTAGE_BYPASS_EN
    // Equality with a one-hot wb_sel implies the read select is one-hot too.
    assign hazard  = 1'b0;
    assign opa_nxt = (wb_ok && (sel1 == wb_sel)) ? wb_data : rd_a;
    assign opb_nxt = (wb_ok && (sel2 == wb_sel)) ? wb_data : rd_b;
`else
    // Stall the read one cycle; the decoder holds and retries after the write.
    assign hazard  = in_valid && wb_ok && ((wb_sel & (sel1 | sel2)) != 4'd0);
    assign opa_nxt = rd_a;
    assign opb_nxt = rd_b;
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_opa   <= '0;
            out_opb   <= '0;
            out_dst   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_code  <= in_code;
            out_opa   <= opa_nxt;
            out_opb   <= opb_nxt;
            out_dst   <= sel1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Bad read selects only count when the entry is actually taken.
    assign err_set = (xfer && !(is_onehot4(sel1) && is_onehot4(sel2)))
                   || (wb_en && !is_onehot4(wb_sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_err <= 1'b0;
        else if (err_set)
            sel_err <= 1'b1;
        else if (err_clr)
            sel_err <= 1'b0;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

`ifdef ALU_OPSTAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [3:0] in_code;
    logic [7:0] in_regsel;
    logic       wb_en;
    logic [3:0] wb_sel;
    logic [7:0] wb_data;
    logic       out_valid, out_ready;
    logic [3:0] out_code, out_dst;
    logic [7:0] out_opa, out_opb;
    logic       sel_err, err_clr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_reg [4];
    logic       m_vld, m_err;
    logic [3:0] m_code, m_dst;
    logic [7:0] m_opa, m_opb;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_regsel(in_regsel),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_opa(out_opa), .out_opb(out_opb), .out_dst(out_dst),
        .sel_err(sel_err), .err_clr(err_clr)
    );

    function automatic logic oh(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [7:0] mread(input logic [3:0] s);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 4; i++)
            if (s == (4'b0001 << i)) r = m_reg[i];
        return r;
    endfunction

    function automatic logic [7:0] mop(input logic [3:0] s);
        if (BYP && wb_en && oh(wb_sel) && s == wb_sel) return wb_data;
        return mread(s);
    endfunction

    function automatic logic exp_ready();
        logic hz;
        hz = !BYP && in_valid && wb_en && oh(wb_sel)
             && ((wb_sel & (in_regsel[7:4] | in_regsel[3:0])) != 4'd0);
        return (!m_vld || out_ready) && !hz;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_vld = 0; m_err = 0; m_code = 0; m_dst = 0; m_opa = 0; m_opb = 0;
    endtask

    task automatic idle();
        in_valid = 0; in_code = 0; in_regsel = 0;
        wb_en = 0; wb_sel = 0; wb_data = 0; err_clr = 0;
    endtask

    // Advance one clock; the model takes the same inputs the DUT sees.
    task automatic tick();
        logic       xf, berr;
        logic [7:0] na, nb;
        xf   = in_valid && exp_ready();
        na   = mop(in_regsel[7:4]);
        nb   = mop(in_regsel[3:0]);
        berr = (xf && !(oh(in_regsel[7:4]) && oh(in_regsel[3:0]))) || (wb_en && !oh(wb_sel));
        @(posedge clk);
        if (xf) begin
            m_vld = 1; m_code = in_code; m_opa = na; m_opb = nb; m_dst = in_regsel[7:4];
        end else if (out_ready) m_vld = 0;
        if (wb_en && oh(wb_sel))
            for (int i = 0; i < 4; i++) if (wb_sel[i]) m_reg[i] = wb_data;
        if (berr) m_err = 1; else if (err_clr) m_err = 0;
        @(negedge clk);
    endtask

    task automatic wb(input logic [3:0] s, input logic [7:0] d);
        idle(); wb_en = 1; wb_sel = s; wb_data = d; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); out_ready = 1; rst_n = 0; mreset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if ({out_code, out_opa, out_opb, out_dst} !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {out_code, out_opa, out_opb, out_dst}); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", sel_err); end
        @(negedge clk); rst_n = 1; @(negedge clk);
    endtask

    task automatic test_basic();
        wb(4'b0001, 8'h11);
        wb(4'b0010, 8'h22);
        in_valid = 1; in_regsel = 8'b0001_0010; in_code = 4'd3; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
        tick(); idle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_opa !== 8'h11 || out_opb !== 8'h22) begin bad++; $display("FAIL basic_ops got=%h/%h exp=11/22", out_opa, out_opb); end
        total++; if (out_code !== 4'd3 || out_dst !== 4'b0001) begin bad++; $display("FAIL basic_code got=%h/%b exp=3/0001", out_code, out_dst); end
    endtask

    task automatic test_stall();
        out_ready = 0; in_valid = 1; in_regsel = 8'b0010_0001; in_code = 4'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, in_ready); end
            tick();
            total++; if (!(out_valid === 1'b1 && out_code === 4'd3 && out_opa === 8'h11 && out_opb === 8'h22))
                begin bad++; $display("FAIL stall_hold c=%0d got=%b %h %h %h exp=1 3 11 22", c, out_valid, out_code, out_opa, out_opb); end
        end
        out_ready = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
        tick(); idle();
        total++; if (!(out_valid === 1'b1 && out_code === 4'd5 && out_opa === 8'h22 && out_opb === 8'h11))
            begin bad++; $display("FAIL drain_next got=%b %h %h %h exp=1 5 22 11", out_valid, out_code, out_opa, out_opb); end
    endtask

    task automatic test_hazard();
        in_valid = 1; in_regsel = 8'b0100_0100; in_code = 4'd7;
        wb_en = 1; wb_sel = 4'b0100; wb_data = 8'h5A; #1;
        total++; if (in_ready !== BYP) begin bad++; $display("FAIL haz_ready got=%b exp=%b", in_ready, BYP); end
        tick();
        if (!BYP) begin
            wb_en = 0; wb_sel = 0; wb_data = 0; #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_retry got=%b exp=1", in_ready); end
            tick();
        end
        idle();
        total++; if (!(out_valid === 1'b1 && out_opa === 8'h5A && out_opb === 8'h5A && out_dst === 4'b0100 && out_code === 4'd7))
            begin bad++; $display("FAIL haz_ops got=%b %h %h %b exp=1 5a 5a 0100", out_valid, out_opa, out_opb, out_dst); end
    endtask

    task automatic test_selerr();
        in_valid = 1; in_regsel = 8'b0011_0000; in_code = 4'd1; tick(); idle();
        total++; if (!(out_valid === 1'b1 && out_opa === 8'h00 && out_opb === 8'h00)) begin bad++; $display("FAIL bad_sel_ops got=%b %h %h exp=1 00 00", out_valid, out_opa, out_opb); end
        total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL bad_sel_err got=%b exp=1", sel_err); end
        err_clr = 1; tick(); idle();
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", sel_err); end
        wb(4'b0110, 8'h77);
        total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL bad_wb_err got=%b exp=1", sel_err); end
        in_valid = 1; in_regsel = 8'b0010_0100; in_code = 4'd2; err_clr = 1; tick(); idle();
        total++; if (out_opa !== 8'h22 || out_opb !== 8'h5A) begin bad++; $display("FAIL bad_wb_nowrite got=%h/%h exp=22/5a", out_opa, out_opb); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL err_clr2 got=%b exp=0", sel_err); end
    endtask

    task automatic test_wb_after();
        wb(4'b1000, 8'h3C);
        in_valid = 1; in_regsel = 8'b1000_0001; in_code = 4'd9; tick(); idle();
        out_ready = 0; wb_en = 1; wb_sel = 4'b1000; wb_data = 8'hFF; tick(); idle();
        total++; if (!(out_valid === 1'b1 && out_opa === 8'h3C && out_opb === 8'h11 && out_dst === 4'b1000))
            begin bad++; $display("FAIL wb_after_held got=%b %h %h %b exp=1 3c 11 1000", out_valid, out_opa, out_opb, out_dst); end
        out_ready = 1; tick();
        in_valid = 1; in_regsel = 8'b1000_1000; tick(); idle();
        total++; if (out_opa !== 8'hFF || out_opb !== 8'hFF) begin bad++; $display("FAIL wb_after_new got=%h/%h exp=ff/ff", out_opa, out_opb); end
    endtask

    function automatic logic [3:0] rsel();
        if ($urandom_range(9) < 8) return 4'b0001 << $urandom_range(3);
        return 4'($urandom);
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_regsel = {rsel(), rsel()};
            in_code   = 4'($urandom);
            wb_en     = ($urandom_range(2) == 0);
            wb_sel    = rsel();
            wb_data   = 8'($urandom);
            out_ready = ($urandom_range(3) != 0);
            err_clr   = ($urandom_range(7) == 0);
            #1;
            total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready()); end
            tick();
            total++; if ({out_valid, out_code, out_opa, out_opb, out_dst, sel_err} !== {m_vld, m_code, m_opa, m_opb, m_dst, m_err})
                begin bad++; $display("FAIL rnd_out c=%0d got=%b %h %h %h %b %b exp=%b %h %h %h %b %b", c,
                    out_valid, out_code, out_opa, out_opb, out_dst, sel_err, m_vld, m_code, m_opa, m_opb, m_dst, m_err); end
        end
        idle(); out_ready = 1; tick();
    endtask

    task automatic test_reset_mid();
        wb(4'b0001, 8'h99);
        out_ready = 0; in_valid = 1; in_regsel = 8'b0001_0001; in_code = 4'd4; tick(); idle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", out_valid); end
        #2; rst_n = 0; mreset(); #1;
        total++; if (out_valid !== 1'b0 || out_opa !== 8'h00) begin bad++; $display("FAIL rmid_async got=%b %h exp=0 00", out_valid, out_opa); end
        @(negedge clk); rst_n = 1; out_ready = 1;
        in_valid = 1; in_regsel = 8'b0001_1000; in_code = 4'd6; tick(); idle();
        total++; if (!(out_valid === 1'b1 && out_opa === 8'h00 && out_opb === 8'h00)) begin bad++; $display("FAIL rmid_regs got=%b %h %h exp=1 00 00", out_valid, out_opa, out_opb); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_hazard();
        test_selerr();
        test_wb_after();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
